// File: rtl/l2_responder_if.sv
// L1-side and pmem-side buses of l2_responder.
// The slave modport is the cache's view; the master modport is the environment's view (L1 initiator plus physical memory).
interface l2_responder_if #(
  parameter int width = 128
);
  logic [15:0]      mem_address;
  logic             mem_read;
  logic             mem_write;
  logic [width-1:0] mem_wdata;
  logic [width-1:0] mem_rdata;
  logic             mem_resp;

  logic [15:0]      pmem_address;
  logic             pmem_read;
  logic             pmem_write;
  logic [width-1:0] pmem_wdata;
  logic [width-1:0] pmem_rdata;
  logic             pmem_resp;

  modport slave (
    input  mem_address, mem_read, mem_write, mem_wdata, pmem_rdata, pmem_resp,
    output mem_rdata, mem_resp, pmem_address, pmem_read, pmem_write, pmem_wdata
  );

  modport master (
    output mem_address, mem_read, mem_write, mem_wdata, pmem_rdata, pmem_resp,
    input  mem_rdata, mem_resp, pmem_address, pmem_read, pmem_write, pmem_wdata
  );
endinterface

// File: rtl/l2_responder.sv
// Direct-mapped, 16-line, write-back and write-allocate L2 behind an L1 request/response bus.
// Define L2_PERF_COUNTERS_EN to build saturating hit/miss counters; otherwise both counters read 0.
module l2_responder #(
  parameter int width = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  l2_responder_if.slave bus,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
);

  typedef enum logic [1:0] {IDLE, CHECK, WRITEBACK, FILL} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [width-1:0] r_data [16];
  logic [7:0]       r_tag  [16];
  logic [15:0]      r_valid;
  logic [15:0]      r_dirty;

  logic [3:0] w_index;
  logic [7:0] w_req_tag;
  logic [3:0] w_unused_offset;
  logic       w_request;
  logic       w_hit;
  logic       w_write_hit;
  logic       w_wb_done;
  logic       w_fill_done;

  assign w_index         = bus.mem_address[7:4];
  assign w_req_tag       = bus.mem_address[15:8];
  assign w_unused_offset = bus.mem_address[3:0];
  assign w_request       = bus.mem_read | bus.mem_write;
  assign w_hit           = r_valid[w_index] && (r_tag[w_index] == w_req_tag);
  assign w_write_hit     = (r_state == CHECK) && w_hit && bus.mem_write;
  assign w_wb_done       = (r_state == WRITEBACK) && bus.pmem_resp;
  assign w_fill_done     = (r_state == FILL) && bus.pmem_resp;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:      if (w_request) w_next_state = CHECK;
      CHECK: begin
        if (w_hit)                                   w_next_state = IDLE;
        else if (r_valid[w_index] && r_dirty[w_index]) w_next_state = WRITEBACK;
        else                                         w_next_state = FILL;
      end
      WRITEBACK: if (bus.pmem_resp) w_next_state = FILL;
      FILL:      if (bus.pmem_resp) w_next_state = CHECK;
      default:   w_next_state = IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case so no path leaves a latch behind.
  always_comb begin
    bus.mem_resp     = 1'b0;
    bus.mem_rdata    = '0;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = '0;
    bus.pmem_wdata   = '0;
    case (r_state)
      CHECK: if (w_hit) begin
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = r_data[w_index];
      end
      WRITEBACK: begin
        bus.pmem_write   = 1'b1;
        bus.pmem_address = {r_tag[w_index], w_index, 4'h0};
        bus.pmem_wdata   = r_data[w_index];
      end
      FILL: begin
        bus.pmem_read    = 1'b1;
        bus.pmem_address = {w_req_tag, w_index, 4'h0};
      end
      default: ;
    endcase
  end

  // NOTE: data and tag arrays have no reset; valid bits gate their use, and a reset must leave contents intact.
  always_ff @(posedge clk) begin
    if (rst_n && w_fill_done) begin
      r_data[w_index] <= bus.pmem_rdata;
      r_tag[w_index]  <= w_req_tag;
    end else if (rst_n && w_write_hit) begin
      r_data[w_index] <= bus.mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (w_fill_done) begin
      r_valid[w_index] <= 1'b1;
      r_dirty[w_index] <= 1'b0;
    end else if (w_wb_done) begin
      r_dirty[w_index] <= 1'b0;
    end else if (w_write_hit) begin
      r_dirty[w_index] <= 1'b1;
    end
  end

`ifdef L2_PERF_COUNTERS_EN
  // The CHECK that follows a fill is a guaranteed hit and is not counted as one.
  logic        r_from_fill;
  logic [15:0] r_hit_count;
  logic [15:0] r_miss_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_from_fill  <= 1'b0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      r_from_fill <= w_fill_done;
      if ((r_state == CHECK) && w_hit && !r_from_fill && (r_hit_count != 16'hFFFF))
        r_hit_count <= r_hit_count + 16'd1;
      if ((r_state == CHECK) && !w_hit && (r_miss_count != 16'hFFFF))
        r_miss_count <= r_miss_count + 16'd1;
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_l2_responder.sv
// Self-checking bench for l2_responder: transaction-level cache model predicts per-cycle outputs,
// directed scenarios pin known addresses and data, then a randomized request stream follows.
module tb_l2_responder;

  localparam int W = 128;
`ifdef L2_PERF_COUNTERS_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  always #5 clk = ~clk;

  l2_responder_if #(.width(W)) bus ();

  l2_responder #(.width(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .hit_count (hit_count),
    .miss_count(miss_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference cache contents and statistics.
  logic [W-1:0] m_data  [16];
  logic [7:0]   m_tag   [16];
  bit           m_valid [16];
  bit           m_dirty [16];
  int           m_hits  = 0;
  int           m_misses = 0;

  // Expected outputs for the current cycle.
  bit           e_on = 1'b0;
  bit           e_idle, e_resp, e_pread, e_pwrite;
  logic [W-1:0] e_rdata, e_pwdata;
  logic [15:0]  e_paddr;

  // Observations used by the directed literal checks.
  int           n_resp = 0;
  int           n_pmem = 0;
  logic [W-1:0] last_rdata, last_pwdata;
  logic [15:0]  last_raddr, last_waddr;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (e_on) begin
      check("mem_resp",   bus.mem_resp,   e_resp);
      check("pmem_read",  bus.pmem_read,  e_pread);
      check("pmem_write", bus.pmem_write, e_pwrite);
      if (e_resp)             check("mem_rdata",    bus.mem_rdata,    e_rdata);
      if (e_pread || e_pwrite) check("pmem_address", bus.pmem_address, e_paddr);
      if (e_pwrite)           check("pmem_wdata",   bus.pmem_wdata,   e_pwdata);
      if (e_idle) begin
        check("idle_mem_rdata",    bus.mem_rdata,    '0);
        check("idle_pmem_address", bus.pmem_address, '0);
        check("idle_pmem_wdata",   bus.pmem_wdata,   '0);
      end
      check("hit_count",  hit_count,  CNT_EN ? m_hits   : 0);
      check("miss_count", miss_count, CNT_EN ? m_misses : 0);
    end
    if (bus.mem_resp === 1'b1) begin
      n_resp++;
      last_rdata = bus.mem_rdata;
    end
    if (bus.pmem_read === 1'b1) begin
      n_pmem++;
      last_raddr = bus.pmem_address;
    end
    if (bus.pmem_write === 1'b1) begin
      n_pmem++;
      last_waddr  = bus.pmem_address;
      last_pwdata = bus.pmem_wdata;
    end
  end

  function automatic logic [W-1:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_quiet();
    e_on = 1'b1; e_idle = 1'b0; e_resp = 1'b0; e_pread = 1'b0; e_pwrite = 1'b0;
    e_rdata = '0; e_pwdata = '0; e_paddr = '0;
  endtask

  task automatic expect_idle();
    expect_quiet();
    e_idle = 1'b1;
  endtask

  // Stray pmem responses outside a transfer must be ignored.
  task automatic noise();
    bus.pmem_resp  = 1'($urandom_range(0, 1));
    bus.pmem_rdata = rand_line();
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic idle_cycle();
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    noise();
    expect_idle();
    step();
  endtask

  // One L1 request from its IDLE cycle through mem_resp; abort_at >= 0 resets during that FILL cycle.
  task automatic do_req(input logic [15:0] addr, input bit wr, input logic [W-1:0] wd,
                        input logic [W-1:0] fill_line, input int wb_lat, input int fill_lat,
                        input int abort_at);
    int       idx;
    logic [7:0] tag;
    bit       hit, evict;
    idx   = int'(addr[7:4]);
    tag   = addr[15:8];
    hit   = m_valid[idx] && (m_tag[idx] == tag);
    evict = !hit && m_valid[idx] && m_dirty[idx];

    bus.mem_address = addr;
    bus.mem_read    = !wr;
    bus.mem_write   = wr;
    bus.mem_wdata   = wd;
    noise();
    expect_idle();
    step();

    noise();
    expect_quiet();
    if (hit) begin
      e_resp  = 1'b1;
      e_rdata = m_data[idx];
    end
    step();
    if (hit) begin
      m_hits++;
      if (wr) begin
        m_data[idx]  = wd;
        m_dirty[idx] = 1'b1;
      end
      return;
    end
    m_misses++;

    if (evict) begin
      for (int i = 0; i <= wb_lat; i++) begin
        bus.pmem_resp  = (i == wb_lat);
        bus.pmem_rdata = rand_line();
        expect_quiet();
        e_pwrite = 1'b1;
        e_paddr  = {m_tag[idx], 4'(idx), 4'h0};
        e_pwdata = m_data[idx];
        step();
      end
      m_dirty[idx] = 1'b0;
    end

    for (int i = 0; i <= fill_lat; i++) begin
      bus.pmem_resp  = (i == fill_lat);
      bus.pmem_rdata = (i == fill_lat) ? fill_line : rand_line();
      expect_quiet();
      e_pread = 1'b1;
      e_paddr = {tag, 4'(idx), 4'h0};
      if (i == abort_at) begin
        rst_n         = 1'b0;
        bus.pmem_resp = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        step();
        model_reset();
        rst_n = 1'b1;
        return;
      end
      step();
    end
    m_data[idx]  = fill_line;
    m_tag[idx]   = tag;
    m_valid[idx] = 1'b1;
    m_dirty[idx] = 1'b0;

    noise();
    expect_quiet();
    e_resp  = 1'b1;
    e_rdata = fill_line;
    step();
    if (wr) begin
      m_data[idx]  = wd;
      m_dirty[idx] = 1'b1;
    end
  endtask

  initial begin
    logic [W-1:0] a5_line;
    logic [7:0]   tags [4];
    int           r0, p0;
    a5_line = {16{8'hA5}};
    tags    = '{8'h12, 8'h56, 8'h9A, 8'hEF};

    rst_n           = 1'b0;
    bus.mem_address = '0;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.mem_wdata   = '0;
    bus.pmem_rdata  = '0;
    bus.pmem_resp   = 1'b0;
    model_reset();
    step();
    expect_idle();
    step();
    rst_n = 1'b1;
    idle_cycle();
    idle_cycle();

    // Cold read miss, clean fill.
    r0 = n_resp;
    do_req(16'h1230, 1'b0, '0, a5_line, 0, 2, -1);
    check("req030_resp_pulses", n_resp - r0, 1);
    check("req030_pmem_addr",   last_raddr, 16'h1230);
    check("req030_rdata",       last_rdata, a5_line);
    check("req030_miss_count",  miss_count, CNT_EN ? 16'd1 : 16'd0);
    idle_cycle();

    // Read hit on the same line, different offset.
    r0 = n_resp;
    p0 = n_pmem;
    do_req(16'h123C, 1'b0, '0, '0, 0, 0, -1);
    check("req031_resp_pulses", n_resp - r0, 1);
    check("req031_no_pmem",     n_pmem - p0, 0);
    check("req031_rdata",       last_rdata, a5_line);
    check("req031_hit_count",   hit_count, CNT_EN ? 16'd1 : 16'd0);
    idle_cycle();

    // Write hit dirties the line, conflicting read forces writeback then fill.
    do_req(16'h1230, 1'b1, 128'h1, '0, 0, 0, -1);
    do_req(16'h5630, 1'b0, '0, rand_line(), 1, 1, -1);
    check("req032_wb_addr",   last_waddr,  16'h1230);
    check("req032_wb_data",   last_pwdata, 128'h1);
    check("req032_fill_addr", last_raddr,  16'h5630);
    idle_cycle();

    // Reset during a fill abandons it.
    do_req(16'h9A30, 1'b0, '0, rand_line(), 0, 3, 1);
    check("req033_pread_low", bus.pmem_read, 1'b0);
    idle_cycle();
    p0 = n_pmem;
    do_req(16'h1230, 1'b0, '0, rand_line(), 0, 0, -1);
    check("req033_refill",     n_pmem - p0, 1);
    check("req033_fill_addr",  last_raddr, 16'h1230);
    check("req033_miss_count", miss_count, CNT_EN ? 16'd1 : 16'd0);

    // Randomized traffic over a few conflicting tags, including back-to-back requests.
    for (int n = 0; n < 250; n++) begin
      logic [15:0] a;
      a = {tags[$urandom_range(0, 3)], 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
      do_req(a, 1'($urandom_range(0, 1)), rand_line(), rand_line(),
             $urandom_range(0, 3), $urandom_range(0, 3), -1);
      repeat ($urandom_range(0, 2)) idle_cycle();
    end
    idle_cycle();
    e_on = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/l2_responder.md
L2_RESPONDER -- requirements
Module: l2_responder

Interface
- REQ-001: parameter width, default 128, line width in bits for both the L1-side and pmem-side data buses.
- REQ-002: clk  input  1  single clock; all state updates on its rising edge.
- REQ-003: rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- REQ-004: mem_address  input  16  L1 request byte address: tag [15:8], index [7:4], offset [3:0] (offset ignored).
- REQ-005: mem_read  input  1  L1 line read request, held until mem_resp.
- REQ-006: mem_write  input  1  L1 line write request, held until mem_resp; never asserted together with mem_read.
- REQ-007: mem_wdata  input  width  L1 write line.
- REQ-008: mem_rdata  output  width  line returned to L1; valid while mem_resp=1.
- REQ-009: mem_resp  output  1  one-cycle completion pulse to L1.
- REQ-010: pmem_address  output  16  line address to physical memory, low 4 bits zero.
- REQ-011: pmem_read / pmem_write  output  1 each  physical memory requests, held until pmem_resp.
- REQ-012: pmem_wdata  output  width  writeback line.
- REQ-013: pmem_rdata  input  width  fill line, valid while pmem_resp=1.
- REQ-014: pmem_resp  input  1  physical memory completion pulse.
- REQ-015: hit_count, miss_count  output  16 each  performance counters (see Configuration).

Function
- REQ-016: Block SHALL be a direct-mapped 16-line write-back, write-allocate L2 responding to the L1 initiator protocol; it holds a width x 16 data store, 8-bit tag, valid and dirty bit per line.
- REQ-017: FSM states SHALL be IDLE, CHECK, WRITEBACK, FILL.
- REQ-018: IDLE: mem_read or mem_write high -> CHECK next cycle; all outputs low.
- REQ-019: CHECK, hit (valid and tag match): mem_resp=1 this cycle, mem_rdata=stored line; on write, line<=mem_wdata and dirty<=1 at the edge; -> IDLE. Hit latency: mem_resp in 2nd cycle after request rises.
- REQ-020: CHECK, miss with valid&dirty -> WRITEBACK; miss otherwise -> FILL; mem_resp stays 0.
- REQ-021: WRITEBACK: pmem_write=1, pmem_address={stored tag,index,4'h0}, pmem_wdata=stored line; on pmem_resp -> FILL, dirty<=0.
- REQ-022: FILL: pmem_read=1, pmem_address={request tag,index,4'h0}; on pmem_resp line<=pmem_rdata, tag<=request tag, valid<=1, dirty<=0; -> CHECK (guaranteed hit).
- REQ-023: pmem_read and pmem_write SHALL never be high together; pmem_resp outside WRITEBACK/FILL SHALL be ignored.
- REQ-024: mem_resp SHALL be exactly one cycle; request inputs SHALL be assumed stable from request to mem_resp.
- REQ-025: Back-to-back: request still high in IDLE the cycle after mem_resp SHALL be treated as a new request.

Reset
- REQ-026: rst_n=0 at an edge: state<=IDLE, all valid and dirty<=0, counters<=0; mem_resp, pmem_read, pmem_write low from the following cycle.
- REQ-027: Reset mid-WRITEBACK or mid-FILL SHALL abandon the transfer with no array update; data store contents SHALL not be cleared.

Configuration
- REQ-028: Macro L2_PERF_COUNTERS_EN defined: hit_count increments once per CHECK hit not entered from FILL, miss_count once per CHECK miss; both saturate at 16'hFFFF.
- REQ-029: Macro undefined: hit_count and miss_count SHALL be tied to 0 and no counter flops synthesized; all other behaviour identical.

Verification
- REQ-030: Reset, mem_read addr 16'h1230, pmem_rdata=128'hA5..A5 -> pmem_read with 16'h1230, then mem_rdata=128'hA5..A5, mem_resp 1 cycle, miss_count=1.
- REQ-031: Repeat read 16'h123C -> mem_resp 2nd cycle, no pmem activity, hit_count=1.
- REQ-032: mem_write 16'h1230 data 128'h1, then read 16'h5630 -> pmem_write 16'h1230 data 128'h1, then pmem_read 16'h5630.
- REQ-033: rst_n low during FILL -> pmem_read low next cycle, state IDLE; later read 16'h1230 misses.
- REQ-034: Without L2_PERF_COUNTERS_EN, run REQ-030..032 -> hit_count=miss_count=0 throughout, identical mem/pmem traces.
